// File: rtl/fetch_stage_q_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_stage_q_pkg : shared widths, field helpers and ROM constants
// Rev 1.0
// ------------------------------------------------------------------
package fetch_stage_q_pkg;

  localparam int unsigned c_pc_w     = 8;
  localparam int unsigned c_inst_w   = 16;
  localparam int unsigned c_d_w      = 4;
  localparam int unsigned c_addr_w   = 8;
  localparam int unsigned c_tag_w    = 2;
  localparam int unsigned c_qdepth   = 4;

  // ROM image is generated from the address so no external hex file is needed
  localparam int unsigned c_rom_mask = 'h5A;
  localparam int unsigned c_rom_off  = 'h31;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // D field occupies inst[INST_W-5 -: D_W]
  function automatic int unsigned d_lsb(input int unsigned inst_w, input int unsigned d_w);
    return inst_w - 4 - d_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_q_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_stage_q_if : redirect/hold controls and decode-side handshake
// Rev 1.0
// ------------------------------------------------------------------
interface fetch_stage_q_if
  import fetch_stage_q_pkg::*;
#(
  parameter int unsigned PC_W   = c_pc_w,
  parameter int unsigned INST_W = c_inst_w,
  parameter int unsigned D_W    = c_d_w,
  parameter int unsigned ADDR_W = c_addr_w,
  parameter int unsigned TAG_W  = c_tag_w,
  parameter int unsigned QDEPTH = c_qdepth
);

  logic                       fetch_hold;
  logic [TAG_W-1:0]           in_tag;
  logic                       redirect_vld;
  logic [PC_W-1:0]            redirect_pc;
  logic                       out_valid;
  logic                       out_ready;
  logic [PC_W-1:0]            out_pc;
  logic [INST_W-1:0]          out_inst;
  logic [D_W-1:0]             out_d;
  logic [ADDR_W-1:0]          out_addr;
  logic [TAG_W-1:0]           out_tag;
  logic [$clog2(QDEPTH):0]    q_count;

  modport master (
    output fetch_hold, in_tag, redirect_vld, redirect_pc, out_ready,
    input  out_valid, out_pc, out_inst, out_d, out_addr, out_tag, q_count
  );

  modport slave (
    input  fetch_hold, in_tag, redirect_vld, redirect_pc, out_ready,
    output out_valid, out_pc, out_inst, out_d, out_addr, out_tag, q_count
  );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_q_rom.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_stage_q_rom : combinational instruction ROM, PC -> word
// Rev 1.0
// ------------------------------------------------------------------
module fetch_stage_q_rom
  import fetch_stage_q_pkg::*;
#(
  parameter int unsigned PC_W   = c_pc_w,
  parameter int unsigned INST_W = c_inst_w
) (
  input  logic [PC_W-1:0]   addr,
  output logic [INST_W-1:0] data
);

  localparam logic [PC_W-1:0] c_mask = PC_W'(c_rom_mask);
  localparam logic [PC_W-1:0] c_off  = PC_W'(c_rom_off);

  logic [2*PC_W-1:0] w_word;

  assign w_word = {addr ^ c_mask, addr + c_off};
  assign data   = INST_W'(w_word);

endmodule
`default_nettype wire

// File: rtl/fetch_stage_q.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_stage_q : fetch PC, ROM read and prefetch queue with redirect
// Rev 1.0
// ------------------------------------------------------------------
module fetch_stage_q
  import fetch_stage_q_pkg::*;
#(
  parameter int unsigned PC_W   = c_pc_w,
  parameter int unsigned INST_W = c_inst_w,
  parameter int unsigned D_W    = c_d_w,
  parameter int unsigned ADDR_W = c_addr_w,
  parameter int unsigned TAG_W  = c_tag_w,
  parameter int unsigned QDEPTH = c_qdepth
) (
  input  logic            clk,
  input  logic            en,
  fetch_stage_q_if.slave  fs
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned D_LSB = d_lsb(INST_W, D_W);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(QDEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t            r_mem [QDEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [PC_W-1:0]   r_fetch_pc;

  logic [INST_W-1:0] w_rom_data;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  cnt_op_e           w_cnt_op;
  entry_t            w_head;

  fetch_stage_q_rom #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_rom (
    .addr (r_fetch_pc),
    .data (w_rom_data)
  );

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & fs.out_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle
  assign w_push  = ~fs.redirect_vld & ~fs.fetch_hold & ((r_count != c_full) | w_pop);

  always_comb begin
    w_cnt_op = CNT_HOLD;
    if (w_push && !w_pop) begin
      w_cnt_op = CNT_INC;
    end else if (!w_push && w_pop) begin
      w_cnt_op = CNT_DEC;
    end
  end

  always_ff @(posedge clk) begin
    if (!en) begin
      r_fetch_pc <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (fs.redirect_vld) begin
      r_fetch_pc <= fs.redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(1);
        r_tail     <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case (w_cnt_op)
        CNT_INC: r_count <= r_count + CNT_W'(1);
        CNT_DEC: r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (en && w_push) begin
      r_mem[r_tail] <= '{pc: r_fetch_pc, inst: w_rom_data, tag: fs.in_tag};
    end
  end

  assign w_head = r_mem[r_head];

  assign fs.out_valid = w_valid;
  assign fs.q_count   = r_count;
  assign fs.out_pc    = w_valid ? w_head.pc                   : '0;
  assign fs.out_inst  = w_valid ? w_head.inst                 : '0;
  assign fs.out_d     = w_valid ? w_head.inst[D_LSB +: D_W]   : '0;
  assign fs.out_addr  = w_valid ? w_head.inst[ADDR_W-1:0]     : '0;
  assign fs.out_tag   = w_valid ? w_head.tag                  : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_q.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fetch_stage_q : directed vector table plus redirect/hold/reset sequences
// Rev 1.0
// ------------------------------------------------------------------
module tb_fetch_stage_q;

  typedef struct {
    logic       en;
    logic       hold;
    logic [1:0] tag;
    logic       redir;
    logic [7:0] rpc;
    logic       ready;
    logic       ev;
    logic [7:0] epc;
    logic [1:0] etag;
    logic [2:0] ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic en;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_delivered = 0;
  logic [7:0] last_delivered = 8'h00;
  vec_t vecs [$];

  fetch_stage_q_if fs ();

  fetch_stage_q dut (
    .clk (clk),
    .en  (en),
    .fs  (fs)
  );

  always #5 clk = ~clk;

  // Reference ROM image: high byte pc^0x5A, low byte pc+0x31
  function automatic logic [15:0] rom_model(input logic [7:0] pc);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = pc ^ 8'h5A;
    lo = pc + 8'h31;
    return {hi, lo};
  endfunction

  function automatic vec_t mk(input logic e, input logic h, input logic [1:0] t,
                              input logic r, input logic [7:0] rp, input logic rd,
                              input logic ev, input logic [7:0] epc,
                              input logic [1:0] etag, input logic [2:0] ecnt);
    vec_t v;
    v.en = e; v.hold = h; v.tag = t; v.redir = r; v.rpc = rp; v.ready = rd;
    v.ev = ev; v.epc = epc; v.etag = etag; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic e, input logic h, input logic [1:0] t,
                       input logic r, input logic [7:0] rp, input logic rd);
    @(negedge clk);
    en              = e;
    fs.fetch_hold   = h;
    fs.in_tag       = t;
    fs.redirect_vld = r;
    fs.redirect_pc  = rp;
    fs.out_ready    = rd;
    #1;
    if (fs.out_valid && rd && e) begin
      n_delivered++;
      last_delivered = fs.out_pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic ev, input logic [7:0] epc,
                       input logic [1:0] etag, input logic [2:0] ecnt);
    logic [15:0] ei;
    logic [7:0]  pcx;
    logic [1:0]  tgx;
    ei  = ev ? rom_model(epc) : 16'h0000;
    pcx = ev ? epc : 8'h00;
    tgx = ev ? etag : 2'b00;
    cmp({nm, " valid"}, 32'(fs.out_valid), 32'(ev));
    cmp({nm, " count"}, 32'(fs.q_count),   32'(ecnt));
    cmp({nm, " pc"},    32'(fs.out_pc),    32'(pcx));
    cmp({nm, " inst"},  32'(fs.out_inst),  32'(ei));
    cmp({nm, " d"},     32'(fs.out_d),     32'(ei[11:8]));
    cmp({nm, " addr"},  32'(fs.out_addr),  32'(ei[7:0]));
    cmp({nm, " tag"},   32'(fs.out_tag),   32'(tgx));
  endtask

  initial begin
    en              = 1'b0;
    fs.fetch_hold   = 1'b0;
    fs.in_tag       = 2'b00;
    fs.redirect_vld = 1'b0;
    fs.redirect_pc  = 8'h00;
    fs.out_ready    = 1'b0;

    // Reset, then streaming with ready high: one entry per cycle
    vecs.push_back(mk(0,0,0,0,8'h00,0, 0,8'h00,0,0));
    vecs.push_back(mk(0,0,0,0,8'h00,0, 0,8'h00,0,0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1,0,2'(i),0,8'h00,1, 1,8'(i),2'(i),1));
    // Reset again, stall decode until the queue saturates, then drain
    vecs.push_back(mk(0,0,0,0,8'h00,1, 0,8'h00,0,0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,0,1,0,8'h00,0, 1,8'h00,1,3'((i < 3) ? i + 1 : 4)));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,0,1,0,8'h00,1, 1,8'(i + 1),1,4));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].en, vecs[i].hold, vecs[i].tag, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].etag, vecs[i].ecnt);
    end

    // Redirect while full, head popped in the same cycle
    apply(0,0,0,0,8'h00,0); check("rst_a", 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) apply(1,0,0,0,8'h00,0);
    check("full", 1, 8'h00, 0, 4);
    n_delivered = 0;
    apply(1,0,0,1,8'h40,1);
    cmp("redir delivered count", 32'(n_delivered), 32'd1);
    cmp("redir delivered pc", 32'(last_delivered), 32'h00);
    check("redir_flush", 0, 8'h00, 0, 0);
    apply(1,0,0,0,8'h00,1); check("redir_40", 1, 8'h40, 0, 1);
    apply(1,0,0,0,8'h00,1); check("redir_41", 1, 8'h41, 0, 1);

    // Redirect near the top of the PC space and wrap
    apply(1,0,0,1,8'hFE,1); check("wrap_flush", 0, 8'h00, 0, 0);
    apply(1,0,0,0,8'h00,1); check("wrap_fe", 1, 8'hFE, 0, 1);
    apply(1,0,0,0,8'h00,1); check("wrap_ff", 1, 8'hFF, 0, 1);
    apply(1,0,0,0,8'h00,1); check("wrap_00", 1, 8'h00, 0, 1);

    // Fill three entries with distinct tags, then drain under fetch_hold
    apply(1,0,0,1,8'h10,0); check("hold_flush", 0, 8'h00, 0, 0);
    apply(1,0,1,0,8'h00,0); check("hold_f1", 1, 8'h10, 1, 1);
    apply(1,0,2,0,8'h00,0); check("hold_f2", 1, 8'h10, 1, 2);
    apply(1,0,3,0,8'h00,0); check("hold_f3", 1, 8'h10, 1, 3);
    apply(1,1,0,0,8'h00,1); check("hold_d1", 1, 8'h11, 2, 2);
    apply(1,1,0,0,8'h00,1); check("hold_d2", 1, 8'h12, 3, 1);
    apply(1,1,0,0,8'h00,1); check("hold_d3", 0, 8'h00, 0, 0);
    apply(1,1,0,0,8'h00,1); check("hold_idle", 0, 8'h00, 0, 0);
    apply(1,0,2,0,8'h00,0); check("hold_rel", 1, 8'h13, 2, 1);

    // Reset mid-stream with three entries; reset beats a concurrent redirect
    apply(1,0,0,0,8'h00,0); check("mid_2", 1, 8'h13, 2, 2);
    apply(1,0,0,0,8'h00,0); check("mid_3", 1, 8'h13, 2, 3);
    apply(0,0,0,1,8'h80,0); check("mid_rst", 0, 8'h00, 0, 0);
    apply(1,0,0,0,8'h00,1); check("mid_pc0", 1, 8'h00, 0, 1);
    apply(1,0,0,0,8'h00,1); check("mid_pc1", 1, 8'h01, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
